// File: rtl/sha256_nonce_sequencer_pkg.sv
// sha256_nonce_sequencer_pkg: shared constants, state encoding and block builder
package sha256_nonce_sequencer_pkg;
  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] LEN_640 = 32'h00000280;
  localparam int LATENCY = 65;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic logic [511:0] build_block(input logic [95:0] data, input logic [31:0] nonce);
    build_block = {LEN_640, 320'd0, PAD_WORD, nonce, data};
  endfunction
endpackage

// File: rtl/sha256_nonce_sequencer_if.sv
// sha256_nonce_sequencer_if: work, transform and golden-nonce signals of the sequencer
interface sha256_nonce_sequencer_if;
  logic work_valid;
  logic work_ready;
  logic [255:0] work_midstate;
  logic [95:0] work_data;
  logic [31:0] work_nonce_start;
  logic [31:0] work_nonce_end;
  logic tx_feedback;
  logic [5:0] tx_cnt;
  logic [255:0] tx_state;
  logic [511:0] tx_input;
  logic [255:0] rx_hash;
  logic golden_valid;
  logic golden_ready;
  logic [31:0] golden_nonce;
  logic golden_dropped;
  logic busy;
  logic done;
  modport slave (
    input work_valid, work_midstate, work_data, work_nonce_start, work_nonce_end, rx_hash, golden_ready,
    output work_ready, tx_feedback, tx_cnt, tx_state, tx_input, golden_valid, golden_nonce, golden_dropped,
    busy, done
  );
  modport master (
    output work_valid, work_midstate, work_data, work_nonce_start, work_nonce_end, rx_hash, golden_ready,
    input work_ready, tx_feedback, tx_cnt, tx_state, tx_input, golden_valid, golden_nonce, golden_dropped,
    busy, done
  );
endinterface

// File: rtl/sha256_tag_pipe.sv
// sha256_tag_pipe: in-flight nonce tags, shifted once per slot, presented in the hash check cycle
module sha256_tag_pipe
  import sha256_nonce_sequencer_pkg::*;
#(
  parameter int LOOP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  input  logic        chk,
  input  logic        in_valid,
  input  logic [31:0] in_nonce,
  output logic        out_valid,
  output logic [31:0] out_nonce,
  output logic        pending
);
  // the last stage becomes current exactly LATENCY cycles after its slot
  localparam int DEPTH = (LATENCY - 1) / LOOP + 1;
  logic [DEPTH-1:0] v;
  logic [31:0] n [DEPTH];
  always_ff @(posedge clk or posedge reset)
    if (reset) v <= '0;
    else if (adv) v <= {v[DEPTH-2:0], in_valid};
  always_ff @(posedge clk)
    if (adv) begin
      n[0] <= in_nonce;
      for (int i = 1; i < DEPTH; i++) n[i] <= n[i-1];
    end
  assign out_valid = v[DEPTH-1] & chk;
  assign out_nonce = n[DEPTH-1];
  assign pending = |v[DEPTH-2:0];
endmodule

// File: rtl/sha256_nonce_sequencer.sv
// sha256_nonce_sequencer: feeds nonces to a LOOP-folded SHA-256 transform and reports golden nonces
module sha256_nonce_sequencer
  import sha256_nonce_sequencer_pkg::*;
#(
  parameter int LOOP = 4,
  parameter int MATCH_BITS = 32
) (
  input logic clk,
  input logic reset,
  sha256_nonce_sequencer_if.slave bus
);
  state_t state, state_n;
  logic [5:0] cnt;
  logic [95:0] data;
  logic [31:0] nonce, nonce_end, golden_nonce, tag_nonce;
  logic [255:0] mid;
  logic [511:0] blk;
  logic issue_v, golden_valid, golden_dropped, done;
  logic pre, accept, tag_valid, pending, last_chk, hit, take;
  // registers load on the edge before a slot so the new block is visible during the slot
  assign pre = cnt == 6'(LOOP - 1);
  assign accept = state == IDLE && bus.work_valid;
  assign last_chk = tag_valid && !pending && !issue_v;
  assign hit = tag_valid && bus.rx_hash[255 -: MATCH_BITS] == '0;
  assign take = hit && (!golden_valid || bus.golden_ready);
  sha256_tag_pipe #(.LOOP(LOOP)) u_tags (
    .clk(clk),
    .reset(reset),
    .adv(cnt == 6'd0),
    .chk(cnt == 6'(LATENCY % LOOP)),
    .in_valid(issue_v),
    .in_nonce(blk[127:96]),
    .out_valid(tag_valid),
    .out_nonce(tag_nonce),
    .pending(pending)
  );
  always_comb begin
    state_n = state;
    if (accept) state_n = RUN;
    else if (state == RUN && pre && nonce == nonce_end) state_n = DRAIN;
    else if (state == DRAIN && last_chk) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      data <= '0;
      nonce <= '0;
      nonce_end <= '0;
      mid <= '0;
      blk <= '0;
      issue_v <= 1'b0;
      golden_valid <= 1'b0;
      golden_nonce <= '0;
      golden_dropped <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt <= pre ? 6'd0 : cnt + 6'd1;
      done <= state == DRAIN && last_chk;
      if (accept) begin
        mid <= bus.work_midstate;
        data <= bus.work_data;
        nonce <= bus.work_nonce_start;
        nonce_end <= bus.work_nonce_end;
      end
      if (pre) issue_v <= state == RUN;
      if (pre && state == RUN) begin
        blk <= build_block(data, nonce);
        nonce <= nonce + 32'd1;
      end
      if (take) begin
        golden_valid <= 1'b1;
        golden_nonce <= tag_nonce;
      end else if (golden_valid && bus.golden_ready) golden_valid <= 1'b0;
      golden_dropped <= accept ? 1'b0 : golden_dropped | (hit && !take);
    end
  assign bus.work_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.tx_cnt = cnt;
  assign bus.tx_feedback = cnt != 6'd0;
  assign bus.tx_state = mid;
  assign bus.tx_input = blk;
  assign bus.golden_valid = golden_valid;
  assign bus.golden_nonce = golden_nonce;
  assign bus.golden_dropped = golden_dropped;
  assign bus.done = done;
endmodule

// File: tb/tb_sha256_nonce_sequencer.sv
// tb_sha256_nonce_sequencer: directed checks of the sequencer against a 65-cycle transform model
module tb_sha256_nonce_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  int cyc = 0, pass_n = 0, chk_n = 0;
  logic hen0 = 1'b0, hen1 = 1'b0;
  logic [31:0] hn0 = '0, hn1 = '0;
  sha256_nonce_sequencer_if ifa ();
  sha256_nonce_sequencer_if ifb ();
  sha256_nonce_sequencer #(.LOOP(4), .MATCH_BITS(32)) dut4 (.clk(clk), .reset(reset), .bus(ifa.slave));
  sha256_nonce_sequencer #(.LOOP(1), .MATCH_BITS(32)) dut1 (.clk(clk), .reset(reset), .bus(ifb.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // transform stand-in: hash word 7 is zero only for the programmed nonces
  function automatic logic [255:0] model(input logic [511:0] ti);
    logic [31:0] n;
    n = ti[127:96];
    model = {((hen0 && n == hn0) || (hen1 && n == hn1)) ? 32'd0 : (n ^ 32'h5a5a5a5a) | 32'd1, 224'd1};
  endfunction
  logic [255:0] dla [65];
  logic [255:0] dlb [65];
  always @(posedge clk) begin
    dla[0] <= model(ifa.tx_input);
    dlb[0] <= model(ifb.tx_input);
    for (int i = 1; i < 65; i++) begin
      dla[i] <= dla[i-1];
      dlb[i] <= dlb[i-1];
    end
  end
  assign ifa.rx_hash = dla[64];
  assign ifb.rx_hash = dlb[64];

  logic [511:0] pa = '0, pb = '0;
  logic [31:0] ia[$];
  int ic[$];
  logic [31:0] ga[$];
  logic [31:0] gb[$];
  int ia_bad = 0, da_n = 0, da_c = 0, gva_n = 0, ib_n = 0, db_n = 0, fb_n = 0;
  always @(negedge clk) begin
    if (ifa.tx_input !== pa && ifa.tx_input[159:128] == 32'h80000000) begin
      ia.push_back(ifa.tx_input[127:96]);
      ic.push_back(cyc);
      if (ifa.tx_cnt != 6'd0) ia_bad <= ia_bad + 1;
    end
    pa <= ifa.tx_input;
    if (ifa.done) begin
      da_n <= da_n + 1;
      da_c <= cyc;
    end
    if (ifa.golden_valid) gva_n <= gva_n + 1;
    if (ifa.golden_valid && ifa.golden_ready) ga.push_back(ifa.golden_nonce);
    if (ifb.tx_input !== pb && ifb.tx_input[159:128] == 32'h80000000) ib_n <= ib_n + 1;
    pb <= ifb.tx_input;
    if (ifb.done) db_n <= db_n + 1;
    if (ifb.tx_feedback) fb_n <= fb_n + 1;
    if (ifb.golden_valid && ifb.golden_ready) gb.push_back(ifb.golden_nonce);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic start_a(input logic [95:0] d, input logic [31:0] s, input logic [31:0] e);
    ifa.work_data = d;
    ifa.work_midstate = {8{d[31:0]}};
    ifa.work_nonce_start = s;
    ifa.work_nonce_end = e;
    ifa.work_valid = 1'b1;
    tick();
    ifa.work_valid = 1'b0;
  endtask
  task automatic wait_a(input int bd);
    for (int i = 0; i < 400 && da_n == bd; i++) tick();
    tick(8);
  endtask
  function automatic logic [31:0] iss(input int k);
    iss = (k < ia.size()) ? ia[k] : 32'hxxxxxxxx;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    chk_n++; if (ifa.tx_cnt !== 6'd0 || ifa.tx_feedback !== 1'b0) $display("FAIL reset_cnt got %0d/%b want 0/0", ifa.tx_cnt, ifa.tx_feedback); else pass_n++;
    chk_n++; if (ifa.tx_input !== 512'd0) $display("FAIL reset_input got %h want 0", ifa.tx_input[127:0]); else pass_n++;
    chk_n++; if (ifa.tx_state !== 256'd0) $display("FAIL reset_state got %h want 0", ifa.tx_state); else pass_n++;
    chk_n++; if ({ifa.golden_valid, ifa.golden_dropped, ifa.done, ifa.busy} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {ifa.golden_valid, ifa.golden_dropped, ifa.done, ifa.busy}); else pass_n++;
    chk_n++; if (ifa.golden_nonce !== 32'd0 || ifa.work_ready !== 1'b1) $display("FAIL reset_nonce_ready got %h/%b want 0/1", ifa.golden_nonce, ifa.work_ready); else pass_n++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic;
    int bi = ia.size(), bd = da_n, bg = gva_n, last;
    hen0 = 1'b0; hen1 = 1'b0;
    start_a(96'h0000000c_0000000b_0000000a, 32'd0, 32'd3);
    chk_n++; if (ifa.busy !== 1'b1 || ifa.work_ready !== 1'b0) $display("FAIL basic_busy got %b/%b want 1/0", ifa.busy, ifa.work_ready); else pass_n++;
    wait_a(bd);
    chk_n++; if (ia.size() - bi !== 4) $display("FAIL basic_issues got %0d want 4", ia.size() - bi); else pass_n++;
    for (int k = 0; k < 4; k++) begin
      chk_n++; if (iss(bi + k) !== 32'(k)) $display("FAIL basic_nonce%0d got %h want %h", k, iss(bi + k), k); else pass_n++;
    end
    last = ic.size() > 0 ? ic[ic.size()-1] : 0;
    chk_n++; if (ic.size() < bi + 4 || last - ic[bi] !== 12) $display("FAIL basic_spacing got %0d want 12", last - ic[bi]); else pass_n++;
    chk_n++; if (ia_bad !== 0) $display("FAIL basic_slot_phase got %0d want 0", ia_bad); else pass_n++;
    chk_n++; if (da_n - bd !== 1) $display("FAIL basic_done_count got %0d want 1", da_n - bd); else pass_n++;
    chk_n++; if (da_c !== last + 66) $display("FAIL basic_done_cycle got %0d want %0d", da_c, last + 66); else pass_n++;
    chk_n++; if (ifa.busy !== 1'b0) $display("FAIL basic_idle got %b want 0", ifa.busy); else pass_n++;
    chk_n++; if (gva_n !== bg) $display("FAIL basic_no_golden got %0d want %0d", gva_n, bg); else pass_n++;
    chk_n++; if (ifa.tx_input[159:128] !== 32'h80000000) $display("FAIL basic_w4 got %h want 80000000", ifa.tx_input[159:128]); else pass_n++;
    chk_n++; if (ifa.tx_input[511:480] !== 32'h00000280) $display("FAIL basic_w15 got %h want 00000280", ifa.tx_input[511:480]); else pass_n++;
    chk_n++; if (ifa.tx_input[95:0] !== 96'h0000000c_0000000b_0000000a || ifa.tx_input[479:160] !== 320'd0) $display("FAIL basic_words got %h want 0000000c0000000b0000000a", ifa.tx_input[95:0]); else pass_n++;
    chk_n++; if (ifa.tx_state !== {8{32'h0000000a}}) $display("FAIL basic_state got %h want 0000000a x8", ifa.tx_state[31:0]); else pass_n++;
  endtask

  task automatic test_hit;
    int bd = da_n, bg = gva_n, ba = ga.size();
    ifa.golden_ready = 1'b1;
    hn0 = 32'd17; hen0 = 1'b1;
    start_a(96'h1, 32'd10, 32'd20);
    wait_a(bd);
    chk_n++; if (da_n - bd !== 1) $display("FAIL hit_done got %0d want 1", da_n - bd); else pass_n++;
    chk_n++; if (ga.size() - ba !== 1) $display("FAIL hit_count got %0d want 1", ga.size() - ba); else pass_n++;
    chk_n++; if (ga.size() == 0 || ga[ga.size()-1] !== 32'd17) $display("FAIL hit_nonce got %h want 00000011", ga.size() ? ga[ga.size()-1] : 32'hx); else pass_n++;
    chk_n++; if (gva_n - bg !== 1) $display("FAIL hit_valid_cycles got %0d want 1", gva_n - bg); else pass_n++;
    hen0 = 1'b0;
  endtask

  task automatic test_wrap;
    int bi = ia.size(), bd = da_n;
    logic [31:0] want [4];
    want = '{32'hfffffffe, 32'hffffffff, 32'h0, 32'h1};
    start_a(96'h2, 32'hfffffffe, 32'h1);
    wait_a(bd);
    chk_n++; if (ia.size() - bi !== 4) $display("FAIL wrap_issues got %0d want 4", ia.size() - bi); else pass_n++;
    for (int k = 0; k < 4; k++) begin
      chk_n++; if (iss(bi + k) !== want[k]) $display("FAIL wrap_nonce%0d got %h want %h", k, iss(bi + k), want[k]); else pass_n++;
    end
    chk_n++; if (da_n - bd !== 1) $display("FAIL wrap_done got %0d want 1", da_n - bd); else pass_n++;
  endtask

  task automatic test_backpressure;
    int bd = da_n, bi;
    ifa.golden_ready = 1'b0;
    hn0 = 32'd5; hn1 = 32'd6; hen0 = 1'b1; hen1 = 1'b1;
    start_a(96'h3, 32'd4, 32'd7);
    wait_a(bd);
    chk_n++; if (ifa.golden_valid !== 1'b1 || ifa.golden_nonce !== 32'd5) $display("FAIL bp_hold got %b/%h want 1/00000005", ifa.golden_valid, ifa.golden_nonce); else pass_n++;
    chk_n++; if (ifa.golden_dropped !== 1'b1) $display("FAIL bp_dropped got %b want 1", ifa.golden_dropped); else pass_n++;
    ifa.golden_ready = 1'b1;
    tick();
    ifa.golden_ready = 1'b0;
    chk_n++; if (ifa.golden_valid !== 1'b0) $display("FAIL bp_release got %b want 0", ifa.golden_valid); else pass_n++;
    hen0 = 1'b0; hen1 = 1'b0;
    bd = da_n; bi = ia.size();
    start_a(96'h4, 32'd50, 32'd50);
    chk_n++; if (ifa.golden_dropped !== 1'b0) $display("FAIL bp_clear_dropped got %b want 0", ifa.golden_dropped); else pass_n++;
    wait_a(bd);
    chk_n++; if (ia.size() - bi !== 1 || iss(bi) !== 32'd50) $display("FAIL bp_single got %0d/%h want 1/00000032", ia.size() - bi, iss(bi)); else pass_n++;
  endtask

  task automatic test_reset_drain;
    int bi = ia.size(), bd = da_n, bg = gva_n;
    ifa.golden_ready = 1'b1;
    hn0 = 32'd33; hen0 = 1'b1;
    start_a(96'h5, 32'd30, 32'd33);
    for (int i = 0; i < 200 && ia.size() < bi + 4; i++) tick();
    tick(10);
    chk_n++; if (ifa.busy !== 1'b1 || ia.size() - bi !== 4) $display("FAIL rd_in_drain got %b/%0d want 1/4", ifa.busy, ia.size() - bi); else pass_n++;
    reset = 1'b1;
    tick();
    chk_n++; if (ifa.tx_cnt !== 6'd0 || ifa.tx_input !== 512'd0 || ifa.tx_state !== 256'd0) $display("FAIL rd_reset_tx got %0d/%h want 0/0", ifa.tx_cnt, ifa.tx_input[127:96]); else pass_n++;
    chk_n++; if ({ifa.busy, ifa.golden_valid, ifa.done} !== 3'b0) $display("FAIL rd_reset_flags got %b want 000", {ifa.busy, ifa.golden_valid, ifa.done}); else pass_n++;
    reset = 1'b0;
    tick(100);
    chk_n++; if (gva_n !== bg || da_n !== bd) $display("FAIL rd_abandoned got %0d/%0d want %0d/%0d", gva_n, da_n, bg, bd); else pass_n++;
    hen0 = 1'b0;
    bi = ia.size();
    start_a(96'h6, 32'd40, 32'd41);
    wait_a(bd);
    chk_n++; if (da_n - bd !== 1) $display("FAIL rd_next_done got %0d want 1", da_n - bd); else pass_n++;
    chk_n++; if (ia.size() - bi !== 2 || iss(bi) !== 32'd40 || iss(bi + 1) !== 32'd41) $display("FAIL rd_next_issues got %0d/%h/%h want 2/28/29", ia.size() - bi, iss(bi), iss(bi + 1)); else pass_n++;
  endtask

  task automatic test_loop1;
    ifb.golden_ready = 1'b1;
    hn0 = 32'd0; hn1 = 32'd99; hen0 = 1'b1; hen1 = 1'b1;
    ifb.work_data = 96'h7;
    ifb.work_midstate = {8{32'h7}};
    ifb.work_nonce_start = 32'd0;
    ifb.work_nonce_end = 32'd99;
    ifb.work_valid = 1'b1;
    tick();
    ifb.work_valid = 1'b0;
    for (int i = 0; i < 400 && db_n == 0; i++) tick();
    tick(8);
    chk_n++; if (db_n !== 1) $display("FAIL l1_done got %0d want 1", db_n); else pass_n++;
    chk_n++; if (ib_n !== 100) $display("FAIL l1_issues got %0d want 100", ib_n); else pass_n++;
    chk_n++; if (gb.size() !== 2) $display("FAIL l1_hits got %0d want 2", gb.size()); else pass_n++;
    chk_n++; if (gb.size() < 2 || gb[0] !== 32'd0 || gb[1] !== 32'd99) $display("FAIL l1_nonces got %h/%h want 0/63", gb.size() > 0 ? gb[0] : 32'hx, gb.size() > 1 ? gb[1] : 32'hx); else pass_n++;
    chk_n++; if (fb_n !== 0 || ifb.tx_cnt !== 6'd0) $display("FAIL l1_feedback got %0d/%0d want 0/0", fb_n, ifb.tx_cnt); else pass_n++;
    chk_n++; if (ifb.busy !== 1'b0) $display("FAIL l1_idle got %b want 0", ifb.busy); else pass_n++;
  endtask

  initial begin
    ifa.work_valid = 1'b0; ifa.work_midstate = '0; ifa.work_data = '0;
    ifa.work_nonce_start = '0; ifa.work_nonce_end = '0; ifa.golden_ready = 1'b0;
    ifb.work_valid = 1'b0; ifb.work_midstate = '0; ifb.work_data = '0;
    ifb.work_nonce_start = '0; ifb.work_nonce_end = '0; ifb.golden_ready = 1'b0;
    test_reset;
    test_basic;
    test_hit;
    test_wrap;
    test_backpressure;
    test_reset_drain;
    test_loop1;
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule
